// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Debounces a raw mechanical switch level. The input is first brought into the
// clk domain by a two-flop synchronizer, then a four-state FSM requires the
// synchronized level to stay unchanged for STABLE_CYCLES consecutive
// qualification cycles before the debounced output follows it.
//
// Parameters
//   STABLE_CYCLES : consecutive cycles the synchronized input must hold before
//                   btn_level changes (2 .. 2**CNT_WIDTH)
//   CNT_WIDTH     : width of the stability counter
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous, active-high reset
//   btn_in    : raw switch level, asynchronous to clk, may bounce
//   btn_level : debounced, registered level (feeds a downstream edge detector)
//   busy      : high while a level change is being qualified
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic busy
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Terminal count: reaching it with the input still stable completes the
  // qualification, so cnt never exceeds it and never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 level_nxt;
  logic                 busy_nxt;

  // Sequential state. s1 may go metastable; only s2 is ever looked at.
  // NOTE: every register here uses non-blocking assignment so all flops
  // sample the pre-edge values; blocking would let s2 see the new s1 in the
  // same edge and collapse the synchronizer to a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s1        <= btn_in;
      s2        <= s1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and counter logic.
  // NOTE: defaults are assigned before the case so every path drives every
  // output; leaving one unassigned on some path would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      LOW: begin
        if (s2) state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode, so they always
  // equal the decode of the current state while being true flop outputs.
  always_comb begin
    level_nxt = (state_nxt == HIGH)      || (state_nxt == WAIT_LOW);
    busy_nxt  = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with STABLE_CYCLES=4, CNT_WIDTH=3.
// Expected values are hand-derived: with btn_in changed right after an edge,
// the first edge that samples it is E1, s2 shows it after E2, the FSM enters
// the WAIT state at E3, counts at E4..E6 and commits at E7.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic busy;

  int vectors     = 0;
  int miscompares = 0;
  int rises       = 0;
  logic prev_level = 1'b0;
  logic train [50];

  button_debounce #(
    .STABLE_CYCLES(4),
    .CNT_WIDTH    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (btn_level && !prev_level) rises++;
    prev_level = btn_level;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_level", 8'(btn_level), 8'd0);
    check("rst_busy",  8'(busy),      8'd0);
    check("rst_cnt",   8'(dut.cnt),   8'd0);
    rst = 1'b0;

    // Clean press: busy after E3..E6, level after E7
    btn_in = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("press_level_E%0d", k), 8'(btn_level), 8'(k >= 7));
      check($sformatf("press_busy_E%0d", k),  8'(busy),      8'(k >= 3 && k <= 6));
    end
    tick();
    tick();

    // Glitch in HIGH: one low cycle gives a one-cycle busy pulse, level holds
    btn_in = 1'b0;
    tick();
    btn_in = 1'b1;
    check("glitch_level_E1", 8'(btn_level), 8'd1);
    check("glitch_busy_E1",  8'(busy),      8'd0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check($sformatf("glitch_level_E%0d", k), 8'(btn_level), 8'd1);
      check($sformatf("glitch_busy_E%0d", k),  8'(busy),      8'(k == 3));
    end
    check("glitch_cnt", 8'(dut.cnt), 8'd0);

    // Clean release: level falls after E7 with no intermediate toggle
    btn_in = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("release_level_E%0d", k), 8'(btn_level), 8'(k < 7));
      check($sformatf("release_busy_E%0d", k),  8'(busy),      8'(k >= 3 && k <= 6));
    end
    tick();

    // Bounce on press: three high cycles never qualify
    for (int k = 1; k <= 8; k++) begin
      btn_in = (k <= 3);
      tick();
      check($sformatf("bounce_level_E%0d", k), 8'(btn_level), 8'd0);
      check($sformatf("bounce_busy_E%0d", k),  8'(busy),      8'(k >= 3 && k <= 5));
    end
    check("bounce_cnt", 8'(dut.cnt), 8'd0);

    // Reset mid-qualification at cnt=2
    btn_in = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    check("midrst_pre_cnt",  8'(dut.cnt), 8'd2);
    check("midrst_pre_busy", 8'(busy),    8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_level", 8'(btn_level), 8'd0);
    check("midrst_busy",  8'(busy),      8'd0);
    check("midrst_cnt",   8'(dut.cnt),   8'd0);
    // btn_in stays high through reset: full requalification, no spurious fall
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("requal_level_E%0d", k), 8'(btn_level), 8'(k >= 7));
      check($sformatf("requal_busy_E%0d", k),  8'(busy),      8'(k >= 3 && k <= 6));
    end

    // Back to LOW before the bounce train
    btn_in = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    check("pretrain_level", 8'(btn_level), 8'd0);

    // Bounce train: alternating runs of 1..3 cycles, ending low
    begin
      logic v;
      int   i;
      v = 1'b0;
      i = 0;
      while (i < 50) begin
        int len;
        len = $urandom_range(1, 3);
        v   = ~v;
        for (int j = 0; j < len && i < 50; j++) begin
          train[i] = v;
          i++;
        end
      end
      train[49] = 1'b0;
    end
    rises = 0;
    prev_level = btn_level;
    for (int k = 0; k < 50; k++) begin
      btn_in = train[k];
      tick();
      check($sformatf("train_level_%0d", k), 8'(btn_level), 8'd0);
    end
    // Stable high after the last transition: rises after E7, exactly once
    btn_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("train_final_level_E%0d", k), 8'(btn_level), 8'(k >= 7));
    end
    check("train_rises", 8'(rises), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
